// File: rtl/serial_add_sub_unit.sv
// -----------------------------------------------------------------------------
// serial_add_sub_unit
//
// Bit-serial adder/subtractor: one 1-bit full-adder cell plus a carry flop,
// processing one bit position per clock, LSB first, over WIDTH cycles.
// Subtraction is A + ~B + 1, so the inversion of B and the forced carry-in
// are applied once when the operands are captured.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - request a new operation (accepted in IDLE or DONE only)
//   sub    - 0 = A + B + C_in, 1 = A - B (captured with start)
//   A, B   - WIDTH-bit operands (captured with start)
//   C_in   - carry-in for add; ignored when sub = 1
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when S / C_out / V are updated
//   S      - WIDTH-bit result, updated only when an operation completes
//   C_out  - final carry out (subtract: 1 = no borrow)
//   V      - signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             V
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] b_q, b_d;       // operand B already conditioned (~B for sub)
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;   // partial result, filled from the MSB end
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             v_q, v_d;

  // The single full-adder cell.
  logic sum_bit;
  logic carry_nxt;

  assign sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through
    // the case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    co_d    = co_q;
    v_d     = v_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start exactly like IDLE for back-to-back operation.
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : C_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish the complete word in one step so S never
          // shows partial bits. carry_q is the carry into the MSB here.
          state_d = DONE;
          s_d     = {sum_bit, res_q[WIDTH-1:1]};
          co_d    = carry_nxt;
          v_d     = carry_q ^ carry_nxt;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values computed above, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      co_q    <= co_d;
      v_q     <= v_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign S     = s_q;
  assign C_out = co_q;
  assign V     = v_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub_unit
//
// Self-checking bench for serial_add_sub_unit. Four instances (WIDTH = 8, 2,
// 16, 32) share the operand buses; each has its own start so operations are
// issued to one width at a time. Expected results come from hand-written
// vectors or from an arithmetic reference model (plain integer add with the
// signed-overflow sign rule).
// -----------------------------------------------------------------------------
module tb_serial_add_sub_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        sub_in;
  logic        cin_in;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  co_v;
  logic [3:0]  ov_v;
  logic [7:0]  s8;
  logic [1:0]  s2;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [31:0] s_v [4];

  int n_tests = 0;
  int n_fail  = 0;

  // Bench-side record of the result each DUT should currently be holding.
  logic [31:0] last_s  [4];
  logic        last_co [4];
  logic        last_v  [4];

  serial_add_sub_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_in),
    .A(a_in[7:0]), .B(b_in[7:0]), .C_in(cin_in),
    .busy(busy_v[0]), .done(done_v[0]), .S(s8), .C_out(co_v[0]), .V(ov_v[0]));

  serial_add_sub_unit #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_in),
    .A(a_in[1:0]), .B(b_in[1:0]), .C_in(cin_in),
    .busy(busy_v[1]), .done(done_v[1]), .S(s2), .C_out(co_v[1]), .V(ov_v[1]));

  serial_add_sub_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_in),
    .A(a_in[15:0]), .B(b_in[15:0]), .C_in(cin_in),
    .busy(busy_v[2]), .done(done_v[2]), .S(s16), .C_out(co_v[2]), .V(ov_v[2]));

  serial_add_sub_unit #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_in),
    .A(a_in), .B(b_in), .C_in(cin_in),
    .busy(busy_v[3]), .done(done_v[3]), .S(s32), .C_out(co_v[3]), .V(ov_v[3]));

  assign s_v[0] = {24'd0, s8};
  assign s_v[1] = {30'd0, s2};
  assign s_v[2] = {16'd0, s16};
  assign s_v[3] = s32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  function automatic int wof(input int idx);
    case (idx)
      0:       return 8;
      1:       return 2;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  // Reference model: integer arithmetic modulo 2^w, carry from bit w,
  // overflow when both addends share a sign that the sum does not.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sb, input logic ci,
                                output logic [31:0] s, output logic co, output logic v);
    longint unsigned mask, am, bm, sum;
    logic sa, sbb, ss;
    mask = (64'd1 << w) - 64'd1;
    am   = 64'(a) & mask;
    bm   = (sb ? 64'(~b) : 64'(b)) & mask;
    sum  = am + bm + (sb ? 64'd1 : 64'(ci));
    s    = 32'(sum & mask);
    co   = sum[w];
    sa   = am[w-1];
    sbb  = bm[w-1];
    ss   = sum[w-1];
    v    = (sa == sbb) && (ss != sa);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s busy[w%0d]", tag, wof(i)), 32'(busy_v[i]), 32'd0);
      check($sformatf("%s done[w%0d]", tag, wof(i)), 32'(done_v[i]), 32'd0);
      check($sformatf("%s S[w%0d]", tag, wof(i)), s_v[i], 32'd0);
      check($sformatf("%s C_out[w%0d]", tag, wof(i)), 32'(co_v[i]), 32'd0);
      check($sformatf("%s V[w%0d]", tag, wof(i)), 32'(ov_v[i]), 32'd0);
    end
  endtask

  // Issue one operation to DUT idx and check busy/done on every edge from
  // the accepting edge to the done cycle. Inputs are scrambled right after
  // acceptance to show they are not re-read. Returns at posedge+1 of the
  // done cycle, so an immediate next call starts during DONE.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sb, input logic ci,
                        input logic [31:0] es, input logic eco, input logic ev,
                        input string nm);
    int w;
    w = wof(idx);
    @(negedge clk);
    a_in = a; b_in = b; sub_in = sb; cin_in = ci;
    start_v[idx] = 1'b1;
    for (int j = 0; j <= w; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) begin
        start_v[idx] = 1'b0;
        a_in = $urandom; b_in = $urandom;
        sub_in = 1'($urandom); cin_in = 1'($urandom);
      end
      check($sformatf("%s busy e%0d", nm, j), 32'(busy_v[idx]), 32'(j < w));
      check($sformatf("%s done e%0d", nm, j), 32'(done_v[idx]), 32'(j == w));
      if (j < w) begin
        check($sformatf("%s S held e%0d", nm, j), s_v[idx], last_s[idx]);
      end else begin
        check($sformatf("%s S", nm), s_v[idx], es);
        check($sformatf("%s C_out", nm), 32'(co_v[idx]), 32'(eco));
        check($sformatf("%s V", nm), 32'(ov_v[idx]), 32'(ev));
        last_s[idx]  = es;
        last_co[idx] = eco;
        last_v[idx]  = ev;
      end
    end
  endtask

  task automatic run_model(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic sb, input logic ci, input string nm);
    logic [31:0] es;
    logic eco, ev;
    model(wof(idx), a, b, sb, ci, es, eco, ev);
    run_op(idx, a, b, sb, ci, es, eco, ev, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        v;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int dones;

    // idx: 0 = W8, 1 = W2, 2 = W16, 3 = W32
    vecs[0] = '{0, 32'h03, 32'h05, 1'b0, 1'b0, 32'h08, 1'b0, 1'b0};
    vecs[1] = '{0, 32'hFF, 32'h01, 1'b0, 1'b1, 32'h01, 1'b1, 1'b0};
    vecs[2] = '{0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1};
    vecs[3] = '{0, 32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0};
    vecs[4] = '{0, 32'h80, 32'h01, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1};
    vecs[5] = '{1, 32'h3, 32'h1, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0};
    vecs[6] = '{1, 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b1};
    vecs[7] = '{2, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1};
    vecs[8] = '{3, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};

    rst_n = 1'b0; start_v = '0; sub_in = 1'b0; cin_in = 1'b0;
    a_in = '0; b_in = '0;
    for (int i = 0; i < 4; i++) begin
      last_s[i] = '0; last_co[i] = 1'b0; last_v[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed vectors; consecutive calls run back-to-back (start in DONE).
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             vecs[i].s, vecs[i].co, vecs[i].v, $sformatf("vec%0d", i));
    end
    idle(3);

    // Start while busy is ignored and the captured operands are unaffected.
    @(negedge clk);
    a_in = 32'h10; b_in = 32'h20; sub_in = 1'b0; cin_in = 1'b0;
    start_v[0] = 1'b1;
    dones = 0;
    for (int j = 0; j <= 8 + 6; j++) begin
      @(posedge clk);
      #1;
      if (j == 0 || j == 3) start_v[0] = 1'b0;
      if (done_v[0]) dones++;
      check($sformatf("hs busy e%0d", j), 32'(busy_v[0]), 32'(j < 8));
      check($sformatf("hs done e%0d", j), 32'(done_v[0]), 32'(j == 8));
      if (j < 8) check($sformatf("hs S held e%0d", j), s_v[0], last_s[0]);
      else       check($sformatf("hs S e%0d", j), s_v[0], 32'h30);
      if (j == 2) begin
        @(negedge clk);
        start_v[0] = 1'b1; a_in = 32'hAA; b_in = 32'h55; sub_in = 1'b1;
      end
    end
    check("hs done count", 32'(dones), 32'd1);
    last_s[0] = 32'h30; last_co[0] = 1'b0; last_v[0] = 1'b0;

    // Reset mid-operation: no done, result registers cleared.
    @(negedge clk);
    a_in = 32'hFF; b_in = 32'hFF; sub_in = 1'b0; cin_in = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("midrun reset");
    for (int i = 0; i < 4; i++) begin
      last_s[i] = '0; last_co[i] = 1'b0; last_v[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      if (done_v[0] || busy_v[0]) dones++;
    end
    check("aborted op activity", 32'(dones), 32'd0);
    run_op(0, 32'h01, 32'h01, 1'b0, 1'b0, 32'h02, 1'b0, 1'b0, "post-reset");
    idle(2);

    // Exhaustive WIDTH=2.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int m = 0; m < 4; m++)
          run_model(1, 32'(a), 32'(b), m[1], m[0], $sformatf("w2 %0d,%0d,%0d", a, b, m));

    // Random vectors against the reference model.
    for (int i = 0; i < 200; i++)
      run_model(0, $urandom, $urandom, 1'($urandom), 1'($urandom), $sformatf("w8 rnd%0d", i));
    for (int i = 0; i < 1000; i++)
      run_model(2, $urandom, $urandom, 1'($urandom), 1'($urandom), $sformatf("w16 rnd%0d", i));
    for (int i = 0; i < 1000; i++)
      run_model(3, $urandom, $urandom, 1'($urandom), 1'($urandom), $sformatf("w32 rnd%0d", i));
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
